// File: rtl/top_level.sv
// top_level: fixed-function Hamming SECDED decode sequencer.
// Each run reads NUM_WORDS 16-bit codewords from dm1 and decodes them one at
// a time, correcting any single error. It writes back the 11-bit message
// with a 2-bit status. ir1 is present so the program image can be loaded
// and inspected, but the sequencer itself is hard-wired.

// Instruction ROM: holds the externally loaded program image in core.
module InstRom #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 9,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             loadEn_i,
  input  logic [AW-1:0]    loadAddr_i,
  input  logic [WIDTH-1:0] loadData_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] instr_o
);

  reg [WIDTH-1:0] core [0:DEPTH-1];

  // Optional in-system load port; the image normally arrives from the bench hierarchically
  always @(posedge clk_i) begin
    if (loadEn_i) core[loadAddr_i] <= loadData_i;
  end

  assign instr_o = core[addr_i];

endmodule

// Data RAM: single-port, combinational read, synchronous write, byte wide.
module DataMem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  reg [7:0] core [0:DEPTH-1];

  // Contents survive req so a preloaded image is still there when a run starts
  always @(posedge clk_i) begin
    if (we_i) core[addr_i] <= wdata_i;
  end

  assign rdata_o = core[addr_i];

endmodule

module top_level #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int DM_DEPTH  = 256,
  parameter int IR_DEPTH  = 1024,
  parameter int IR_WIDTH  = 9
) (
  input  logic clk,
  input  logic req,
  output logic done
);

  localparam int DmAw = $clog2(DM_DEPTH);
  localparam int IrAw = $clog2(IR_DEPTH);
  localparam int IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] wordIdx_q, wordIdx_d;
  logic [7:0]      lowByte_q, lowByte_d;
  logic [7:0]      outLo_q, outLo_d;
  logic [7:0]      outHi_q, outHi_d;

  logic [DmAw-1:0] memAddr;
  logic            memWe;
  logic [7:0]      memWdata;
  logic [7:0]      memRdata;

  logic [DmAw-1:0] srcLoAddr, srcHiAddr, dstLoAddr, dstHiAddr;
  logic            lastWord;

  logic [15:0]     codeword;
  logic [15:0]     fixedWord;
  logic [3:0]      syndrome;
  logic            parity;
  logic [1:0]      status;
  logic [10:0]     message;

  logic [IR_WIDTH-1:0] instrUnused;

  InstRom #(
    .DEPTH (IR_DEPTH),
    .WIDTH (IR_WIDTH),
    .AW    (IrAw)
  ) ir1 (
    .clk_i      (clk),
    .loadEn_i   (1'b0),
    .loadAddr_i ('0),
    .loadData_i ('0),
    .addr_i     (IrAw'(wordIdx_q)),
    .instr_o    (instrUnused)
  );

  DataMem #(
    .DEPTH (DM_DEPTH),
    .AW    (DmAw)
  ) dm1 (
    .clk_i   (clk),
    .we_i    (memWe),
    .addr_i  (memAddr),
    .wdata_i (memWdata),
    .rdata_o (memRdata)
  );

  // Byte addresses of the current word in the input and output regions
  always_comb begin
    srcLoAddr = DmAw'(SRC_BASE + 2 * int'(wordIdx_q));
    srcHiAddr = DmAw'(SRC_BASE + 2 * int'(wordIdx_q) + 1);
    dstLoAddr = DmAw'(DST_BASE + 2 * int'(wordIdx_q));
    dstHiAddr = DmAw'(DST_BASE + 2 * int'(wordIdx_q) + 1);
    lastWord  = (wordIdx_q == IdxW'(NUM_WORDS - 1));
  end

  // SECDED decode of the held low byte plus the high byte on the read port
  always_comb begin
    codeword = {memRdata, lowByte_q};
    syndrome = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (codeword[k]) syndrome = syndrome ^ 4'(k);
    end
    parity    = ^codeword;
    fixedWord = codeword;
    if (parity && (syndrome != 4'd0)) fixedWord[syndrome] = ~fixedWord[syndrome];
    if (parity)                   status = 2'b01;
    else if (syndrome != 4'd0)    status = 2'b10;
    else                          status = 2'b00;
    message = {fixedWord[15:9], fixedWord[7:5], fixedWord[3]};
  end

  // State register; req holds the sequencer at the start of word 0
  always_ff @(posedge clk or posedge req) begin
    if (req) state_q <= RD_LO;
    else     state_q <= state_d;
  end

  // Next-state: four single-access states per word, then park in DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_LO:   state_d = RD_HI;
      RD_HI:   state_d = WR_LO;
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = lastWord ? DONE : RD_LO;
      DONE:    state_d = DONE;
      default: state_d = RD_LO;
    endcase
  end

  // Outputs: drive the single memory port and the done flag from the state
  always_comb begin
    memAddr  = '0;
    memWe    = 1'b0;
    memWdata = 8'd0;
    done     = 1'b0;
    unique case (state_q)
      RD_LO: memAddr = srcLoAddr;
      RD_HI: memAddr = srcHiAddr;
      WR_LO: begin
        memAddr  = dstLoAddr;
        memWe    = 1'b1;
        memWdata = outLo_q;
      end
      WR_HI: begin
        memAddr  = dstHiAddr;
        memWe    = 1'b1;
        memWdata = outHi_q;
      end
      DONE:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // Datapath next values: capture low byte, result bytes and word index
  always_comb begin
    lowByte_d = lowByte_q;
    outLo_d   = outLo_q;
    outHi_d   = outHi_q;
    wordIdx_d = wordIdx_q;
    unique case (state_q)
      RD_LO: lowByte_d = memRdata;
      RD_HI: begin
        outLo_d = message[7:0];
        outHi_d = {status, 3'b000, message[10:8]};
      end
      WR_HI: if (!lastWord) wordIdx_d = wordIdx_q + 1'b1;
      default: wordIdx_d = wordIdx_q;
    endcase
  end

  // Datapath registers, cleared by req so an aborted run restarts at word 0
  always_ff @(posedge clk or posedge req) begin
    if (req) begin
      lowByte_q <= 8'd0;
      outLo_q   <= 8'd0;
      outHi_q   <= 8'd0;
      wordIdx_q <= '0;
    end else begin
      lowByte_q <= lowByte_d;
      outLo_q   <= outLo_d;
      outHi_q   <= outHi_d;
      wordIdx_q <= wordIdx_d;
    end
  end

endmodule

// File: tb/tb_top_level.sv
// tb_top_level: randomized and directed SECDED runs against a brute-force
// nearest-codeword reference model, with a per-cycle check of done timing.
module tb_top_level;

  localparam int NumWords = 15;
  localparam int SrcBase  = 30;
  localparam int DstBase  = 0;
  localparam int Latency  = 4 * NumWords;

  logic clk = 1'b0;
  logic req = 1'b0;
  logic done;

  int checks   = 0;
  int failures = 0;
  int relEdges = 0;
  bit checkEn  = 1'b0;

  logic [15:0] codeWords [NumWords];
  logic [7:0]  memShadow [256];

  top_level dut (
    .clk  (clk),
    .req  (req),
    .done (done)
  );

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  // Count rising edges seen with req low since the last req
  always @(posedge clk) begin
    if (req) relEdges = 0;
    else     relEdges = relEdges + 1;
  end

  // Build a valid SECDED codeword from an 11-bit message
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    c       = '0;
    c[3]    = d[0];
    c[7:5]  = d[3:1];
    c[15:9] = d[10:4];
    c[1]    = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2]    = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4]    = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8]    = ^c[15:9];
    c[0]    = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  // Reference decode: valid word, else the unique codeword one flip away,
  // else an uncorrectable double error
  function automatic logic [15:0] modelOut(input logic [15:0] c);
    logic [15:0] t;
    logic [1:0]  st;
    logic [10:0] d;
    st = 2'b10;
    d  = extract(c);
    if (encode(extract(c)) == c) begin
      st = 2'b00;
    end else begin
      for (int j = 0; j < 16; j++) begin
        t    = c;
        t[j] = ~t[j];
        if (encode(extract(t)) == t) begin
          st = 2'b01;
          d  = extract(t);
        end
      end
    end
    return {st, 3'b000, d};
  endfunction

  function automatic logic [15:0] randomWord();
    logic [15:0] c;
    int          errs;
    int          b0;
    int          b1;
    c    = encode(11'($urandom_range(0, 2047)));
    errs = $urandom_range(0, 2);
    b0   = $urandom_range(0, 15);
    b1   = (b0 + $urandom_range(1, 15)) % 16;
    if (errs >= 1) c[b0] = ~c[b0];
    if (errs == 2) c[b1] = ~c[b1];
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // done must track the edge count exactly whenever the bench is watching
  always @(negedge clk) begin
    if (checkEn) begin
      checks = checks + 1;
      if (done !== (!req && relEdges >= Latency)) begin
        failures = failures + 1;
        $display("[TB] FAIL done_timing actual=%b expected=%b edges=%0d",
                 done, (!req && relEdges >= Latency), relEdges);
      end
    end
  end

  // Load codewords plus sentinel/random fill into dm1 (req must be high)
  task automatic applyStimulus(input bit directed);
    for (int i = 0; i < NumWords; i++) codeWords[i] = randomWord();
    if (directed) begin
      codeWords[0] = 16'h000F;
      codeWords[1] = 16'h0007;
      codeWords[2] = 16'h000E;
      codeWords[3] = 16'h7FFF;
      codeWords[4] = 16'hFFFF;
      codeWords[5] = 16'h0009;
    end
    for (int a = 0; a < 256; a++) memShadow[a] = 8'($urandom_range(0, 255));
    for (int a = DstBase; a < DstBase + 2 * NumWords; a++) memShadow[a] = 8'hA5;
    for (int i = 0; i < NumWords; i++) begin
      memShadow[SrcBase + 2 * i]     = codeWords[i][7:0];
      memShadow[SrcBase + 2 * i + 1] = codeWords[i][15:8];
    end
    for (int a = 0; a < 256; a++) dut.dm1.core[a] = memShadow[a];
  endtask

  function automatic logic [15:0] dstWord(input int i);
    return {dut.dm1.core[DstBase + 2 * i + 1], dut.dm1.core[DstBase + 2 * i]};
  endfunction

  task automatic startRun();
    @(posedge clk);
    #2 req = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    checks = checks + 1;
    if (done !== 1'b1) begin
      failures = failures + 1;
      $display("[TB] FAIL wait_done actual=%b expected=1 after %0d cycles", done, n);
    end
  endtask

  // All outputs against the model, and nothing outside the output region touched
  task automatic checkRun(input string tag);
    int bad;
    for (int i = 0; i < NumWords; i++)
      checkOutput($sformatf("%s_word%0d", tag, i), dstWord(i), modelOut(codeWords[i]));
    bad = 0;
    for (int a = DstBase + 2 * NumWords; a < 256; a++)
      if (dut.dm1.core[a] !== memShadow[a]) bad = bad + 1;
    checkOutput({tag, "_untouched"}, 16'(bad), 16'd0);
  endtask

  initial begin
    #1 req = 1'b1;
    #1 checkEn = 1'b1;
    checkOutput("reset_done", {15'd0, done}, 16'd0);

    // Model pinned to hand-computed decodes
    checkOutput("model_clean",   modelOut(16'h000F), 16'h0001);
    checkOutput("model_single",  modelOut(16'h0007), 16'h4001);
    checkOutput("model_p0",      modelOut(16'h000E), 16'h4001);
    checkOutput("model_top",     modelOut(16'h7FFF), 16'h47FF);
    checkOutput("model_double",  modelOut(16'h0009), 16'h8001);

    // Held in reset: no activity, no writes
    applyStimulus(1'b1);
    repeat (12) @(posedge clk);
    #1 checkOutput("idle_word0", dstWord(0), 16'hA5A5);

    // Directed run
    startRun();
    waitDone();
    checkRun("dir");
    checkOutput("dir_clean",  dstWord(0), 16'h0001);
    checkOutput("dir_single", dstWord(1), 16'h4001);
    checkOutput("dir_p0",     dstWord(2), 16'h4001);
    checkOutput("dir_top",    dstWord(3), 16'h47FF);
    checkOutput("dir_full",   dstWord(4), 16'h07FF);
    checkOutput("dir_double", dstWord(5), 16'h8001);
    repeat (10) @(posedge clk);

    // Random run aborted after 20 edges, then restarted
    @(posedge clk);
    #2 req = 1'b1;
    applyStimulus(1'b0);
    startRun();
    repeat (20) @(posedge clk);
    #2 req = 1'b1;
    @(negedge clk);
    checkOutput("abort_done",  {15'd0, done}, 16'd0);
    checkOutput("abort_word4", dstWord(4), modelOut(codeWords[4]));
    checkOutput("abort_word5", dstWord(5), 16'hA5A5);
    repeat (3) @(posedge clk);
    #2 req = 1'b0;
    waitDone();
    checkRun("abort");
    repeat (5) @(posedge clk);

    // Fresh random runs
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #2 req = 1'b1;
      applyStimulus(1'b0);
      startRun();
      waitDone();
      checkRun($sformatf("rand%0d", r));
      repeat (4) @(posedge clk);
    end

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
